byte_stream_loader: RTL
=======================

Name: byte_stream_loader

Overview:
- Synthesizable program loader between a byte-serial source (host link, UART RX, bench driver) and basic_ram.
- Collects object-file bytes, assembles little-endian 32-bit words (first byte = bits 7:0), and writes them to consecutive word addresses using the basic_ram cs/we/oe/mem_done handshake.
- Replaces bench-only file loading so programs can be loaded before the core is released from reset.

Parameters:
ADDR_W, 32, width of RAM word address and word counter
MAX_WORDS, 1024, maximum words written per load; reaching it without byte_last ends the load with overflow

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load; ignored while busy=1
base_addr  in  ADDR_W  first word address, latched on accepted start
byte_valid  in  1  byte_data/byte_last valid
byte_data  in  8  object-file byte
byte_last  in  1  marks final byte of image
byte_ready  out  1  loader accepts a byte this cycle
mem_address  out  ADDR_W  to basic_ram address
mem_data_in  out  32  to basic_ram data_input
mem_cs  out  1  chip select
mem_we  out  1  write enable
mem_oe  out  1  output enable, always 0
mem_done  in  1  basic_ram write-complete
busy  out  1  load in progress
done  out  1  load finished; held until next start
overflow  out  1  load ended at MAX_WORDS without byte_last
words_written  out  ADDR_W  words committed this load
checksum  out  32  running mod-2^32 sum of written words (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE. byte_ready, mem_cs, mem_we, mem_oe, busy, done, overflow = 0. mem_address, mem_data_in, words_written, checksum = 0. Internal byte index = 0.
- All outputs are registered.
- IDLE/DONE: on start=1, latch base_addr into mem_address. Clear words_written, checksum, done, overflow and byte index. Go to COLLECT; busy=1.
- COLLECT: byte_ready=1. A byte transfers when byte_valid & byte_ready at a rising edge.
  - It goes to lane (index*8) of the assembly register. index increments mod 4.
  - On the 4th byte, or on a byte with byte_last=1, go to WRITE at the same edge.
  - Lanes not yet filled are zero.
- WRITE: byte_ready=0; mem_cs=1, mem_we=1, mem_oe=0; mem_data_in = assembled word. Strobes are visible the cycle after the transferring edge.
  - Hold all signals until mem_done=1 is sampled at a rising edge (latency >=1 cycle, unbounded).
  - At that edge: mem_cs/mem_we -> 0, mem_address+1 (wraps at 2^ADDR_W), words_written+1, checksum += word, assembly register and index cleared.
  - Next state: if last was seen -> DONE. Else if new words_written == MAX_WORDS -> DONE with overflow=1. Else -> COLLECT.
- DONE: busy=0, done=1, byte_ready=0. Outputs hold until start.
- start while busy=1: ignored. byte_valid outside COLLECT: not accepted, no effect.
- mem_done outside WRITE: ignored.
- byte_last on the 4th byte: a single write, then DONE (no empty extra word).
- Reset mid-WRITE: strobes drop immediately; the partial RAM write is abandoned. The bench must not rely on its memory contents.
- Throughput: at most one byte per cycle; minimum 4 + 2 cycles per word with mem_done after 1 cycle.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum updates as above (sum mod 2^32 of every word written, zero-padded partial included).
- Undefined: checksum output tied to 0; no adder or register is synthesized. All other behaviour is identical.

Test Plan:
- Reset, start with base_addr=0x10, send 00 00 A0 E3 then 01 10 81 E2 (last on final byte), mem_done 1 cycle after cs -> writes 0xE3A00000 @0x10, 0xE2811001 @0x11. done=1, words_written=2, checksum=0xC621_1001 (macro on) / 0 (off).
- Send AA BB CC with last on CC -> single write 0x00CCBBAA. done=1, overflow=0.
- MAX_WORDS=2, send 12 bytes without last -> exactly 2 writes, then overflow=1, done=1, byte_ready=0. Remaining bytes are never accepted.
- mem_done delayed 7 cycles -> mem_cs/mem_we/mem_address/mem_data_in stable for all 7 cycles. byte_ready=0 throughout. Pulsing start mid-load changes nothing.
- Assert rst_n=0 during WRITE -> mem_cs=0 and busy=0 immediately (asynchronous). A new start and load after reset completes normally from the new base_addr.

Source files
------------

// File: rtl/byte_stream_loader_if.sv
// Byte stream plus basic_ram bus bundle for byte_stream_loader.
// master: loader side (accepts bytes, drives the RAM strobes).
// slave : environment side (byte source and RAM).
interface byte_stream_loader_if #(
    parameter int ADDR_W = 32
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              mem_cs;
    logic              mem_we;
    logic              mem_oe;
    logic              mem_done;

    modport master (
        input  byte_valid, byte_data, byte_last, mem_done,
        output byte_ready, mem_address, mem_data_in, mem_cs, mem_we, mem_oe
    );

    modport slave (
        output byte_valid, byte_data, byte_last, mem_done,
        input  byte_ready, mem_address, mem_data_in, mem_cs, mem_we, mem_oe
    );
endinterface

// File: rtl/byte_stream_loader.sv
// byte_stream_loader: gathers object-file bytes into little-endian 32-bit
// words and writes them to consecutive basic_ram word addresses.
// Optional macro LOADER_CHECKSUM_EN enables the running checksum register;
// without it the checksum output is tied to zero.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// COLLECT | accepting bytes into the assembly register
// WRITE   | RAM write strobes held until mem_done
// DONE    | load finished, results held until next start
module byte_stream_loader #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    byte_stream_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_W-1:0]    words_written,
    output logic [31:0]          checksum
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t      state, state_next;
    logic [1:0]  idx;
    logic [31:0] asm_word;
    logic [31:0] word_next;
    logic        last_seen;
    logic        start_ok;
    logic        byte_fire;
    logic        word_full;
    logic        write_ack;
    logic        at_limit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Transfer qualifiers and next-state selection.
    always_comb begin
        state_next = state;
        start_ok   = start && ((state == IDLE) || (state == DONE));
        byte_fire  = (state == COLLECT) && bus.byte_valid && bus.byte_ready;
        word_full  = byte_fire && ((idx == 2'd3) || bus.byte_last);
        write_ack  = (state == WRITE) && bus.mem_done;
        at_limit   = (words_written + ONE) == MAX_CNT;
        word_next  = asm_word;
        word_next[{idx, 3'b000} +: 8] = bus.byte_data;
        case (state)
            IDLE, DONE: if (start_ok) state_next = COLLECT;
            COLLECT:    if (word_full) state_next = WRITE;
            WRITE: begin
                if (write_ack) begin
                    if (last_seen || at_limit) state_next = DONE;
                    else                       state_next = COLLECT;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Registered outputs and datapath; strobes follow the next state so they
    // appear the cycle after the edge that moves the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.byte_ready  <= 1'b0;
            bus.mem_cs      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_oe      <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            words_written   <= '0;
            idx             <= '0;
            asm_word        <= '0;
            last_seen       <= 1'b0;
        end else begin
            bus.byte_ready <= (state_next == COLLECT);
            bus.mem_cs     <= (state_next == WRITE);
            bus.mem_we     <= (state_next == WRITE);
            bus.mem_oe     <= 1'b0;
            busy           <= (state_next == COLLECT) || (state_next == WRITE);
            done           <= (state_next == DONE);
            if (start_ok) begin
                bus.mem_address <= base_addr;
                words_written   <= '0;
                overflow        <= 1'b0;
                idx             <= '0;
                asm_word        <= '0;
                last_seen       <= 1'b0;
            end
            if (byte_fire) begin
                asm_word  <= word_next;
                idx       <= idx + 2'd1;
                last_seen <= last_seen | bus.byte_last;
            end
            if (word_full) bus.mem_data_in <= word_next;
            if (write_ack) begin
                bus.mem_address <= bus.mem_address + ONE;
                words_written   <= words_written + ONE;
                asm_word        <= '0;
                idx             <= '0;
                overflow        <= !last_seen && at_limit;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of committed words, restarted by each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         checksum <= '0;
        else if (start_ok)  checksum <= '0;
        else if (write_ack) checksum <= checksum + bus.mem_data_in;
    end
`else
    assign checksum = '0;
`endif
endmodule
